// File: rtl/display_scan_controller_if.sv
// Result handshake between the calculator core and the display scan controller.
// Valid/ready: a result transfers on any rising edge where result_valid && result_ready;
// result_ready does not depend on result_valid, and result is only looked at while valid is high.
interface display_scan_controller_if;
    logic [6:0] result;
    logic       result_valid;
    logic       result_ready;

    modport master (output result, output result_valid, input result_ready);
    modport slave  (input result, input result_valid, output result_ready);
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexed 3-digit scan (low hex, high hex, sign) with a one-entry result buffer
// that commits only at frame boundaries so a frame never shows two results.
module display_scan_controller #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    display_scan_controller_if.slave  res_if,
    input  logic                      blank_en,
    output logic [1:0]                digit,
    output logic [5:0]                display_value,
    output logic                      is_negative,
    output logic                      overflow,
    output logic [3:0]                anodes,
    output logic                      o_dbg_drive
);
    localparam int CNT_W = $clog2(CLK_DIV);

    typedef enum logic {SLOT_BLANK = 1'b0, SLOT_DRIVE = 1'b1} slot_state_t;

    slot_state_t      r_slot;
    logic [CNT_W-1:0] r_div_cnt;
    logic [1:0]       r_digit;
    logic             r_pend_valid;
    logic [5:0]       r_pend_mag;
    logic             r_pend_neg;
    logic             r_pend_ovf;
    logic [5:0]       r_display_value;
    logic             r_is_negative;
    logic             r_overflow;

    logic             w_wrap;
    logic             w_frame_end;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_next;
    logic [6:0]       w_abs;
    logic             w_is_min;

    assign w_wrap      = (r_div_cnt == CNT_W'(CLK_DIV - 1));
    assign w_frame_end = w_wrap && (r_digit == 2'd2);
    assign w_accept    = res_if.result_valid && !r_pend_valid;
    assign w_cnt_next  = w_wrap ? '0 : r_div_cnt + 1'b1;
    // -64 has no positive 7-bit counterpart; it is saturated to 63 and flagged.
    assign w_abs       = res_if.result[6] ? (~res_if.result + 7'd1) : res_if.result;
    assign w_is_min    = (res_if.result == 7'b1000000);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_slot          <= SLOT_BLANK;
            r_div_cnt       <= '0;
            r_digit         <= 2'd0;
            r_pend_valid    <= 1'b0;
            r_pend_mag      <= 6'd0;
            r_pend_neg      <= 1'b0;
            r_pend_ovf      <= 1'b0;
            r_display_value <= 6'd0;
            r_is_negative   <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_div_cnt <= w_cnt_next;
            r_slot    <= (w_cnt_next < CNT_W'(BLANK_CYCLES)) ? SLOT_BLANK : SLOT_DRIVE;
            if (w_wrap) begin
                r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
            end
            // Commit and accept are exclusive: accept needs an empty buffer, commit a full one.
            if (r_pend_valid && w_frame_end) begin
                r_display_value <= r_pend_mag;
                r_is_negative   <= r_pend_neg;
                r_overflow      <= r_pend_ovf;
                r_pend_valid    <= 1'b0;
            end else if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_neg   <= res_if.result[6];
                r_pend_mag   <= w_is_min ? 6'd63 : w_abs[5:0];
                r_pend_ovf   <= w_is_min;
            end
        end
    end

    always_comb begin
        anodes = 4'b1111;
        if (r_slot == SLOT_DRIVE && !blank_en) begin
            anodes[r_digit] = 1'b0;
        end
    end

    assign res_if.result_ready = !r_pend_valid;
    assign digit               = r_digit;
    assign display_value       = r_display_value;
    assign is_negative         = r_is_negative;
    assign overflow            = r_overflow;
    assign o_dbg_drive         = (r_slot == SLOT_DRIVE);
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: every cycle is compared against a reference model
// built from elapsed cycles since reset and a queue of accepted results.
module tb_display_scan_controller;
  localparam int CLK_DIV = 8;
  localparam int BLANK_CYCLES = 2;

  logic       clk;
  logic       reset_n;
  logic       blank_en;
  logic [1:0] digit;
  logic [5:0] display_value;
  logic       is_negative;
  logic       overflow;
  logic [3:0] anodes;
  logic       o_dbg_drive;

  display_scan_controller_if u_if ();

  display_scan_controller #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .res_if        (u_if),
    .blank_en      (blank_en),
    .digit         (digit),
    .display_value (display_value),
    .is_negative   (is_negative),
    .overflow      (overflow),
    .anodes        (anodes),
    .o_dbg_drive   (o_dbg_drive)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int         m_k = 0;
  logic [6:0] exp_q[$];
  logic [5:0] m_val = 0;
  logic       m_neg = 0;
  logic       m_ovf = 0;
  logic       last_accept;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int m_digit();
    return (m_k / CLK_DIV) % 3;
  endfunction

  function automatic logic [3:0] m_anodes(input logic b);
    logic [3:0] a;
    a = 4'b1111;
    if ((m_k % CLK_DIV) >= BLANK_CYCLES && !b) a[m_digit()] = 1'b0;
    return a;
  endfunction

  // driver: one clock with the given inputs, then model update and full output compare
  task automatic drive_cycle(input logic rst_n, input logic v, input logic [6:0] r, input logic b);
    logic frame_end;
    logic accept;
    int   sv;
    reset_n = rst_n;
    u_if.result_valid = v;
    u_if.result = r;
    blank_en = b;
    #1;
    check("ready_pre", u_if.result_ready, exp_q.size() == 0);
    check("anodes_pre", anodes, m_anodes(b));
    frame_end = (m_k % (3 * CLK_DIV)) == (3 * CLK_DIV - 1);
    accept = rst_n && v && (exp_q.size() == 0);
    @(posedge clk);
    #1;
    last_accept = accept;
    if (!rst_n) begin
      m_k = 0;
      exp_q.delete();
      m_val = 0; m_neg = 0; m_ovf = 0;
    end else begin
      if (exp_q.size() != 0 && frame_end) begin
        sv = exp_q[0][6] ? int'(exp_q[0]) - 128 : int'(exp_q[0]);
        m_neg = (sv < 0);
        m_ovf = (sv == -64);
        m_val = m_ovf ? 6'd63 : 6'((sv < 0) ? -sv : sv);
        void'(exp_q.pop_front());
      end else if (accept) begin
        exp_q.push_back(r);
      end
      m_k++;
    end
    check("digit", digit, m_digit());
    check("anodes", anodes, m_anodes(b));
    check("ready", u_if.result_ready, exp_q.size() == 0);
    check("display_value", display_value, m_val);
    check("is_negative", is_negative, m_neg);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 7'($urandom_range(0, 127)), 1'b0);
  endtask

  task automatic send_until_accepted(input logic [6:0] r);
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      drive_cycle(1'b1, 1'b1, r, 1'b0);
      done = last_accept;
    end
    check("accept_timeout", done, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 7'd0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    u_if.result_valid = 1'b0;
    u_if.result = 7'd0;
    blank_en = 1'b0;

    // reset values
    do_reset();
    check("rst_anodes", anodes, 4'b1111);
    check("rst_digit", digit, 0);
    check("rst_value", display_value, 0);
    check("rst_ready", u_if.result_ready, 1);

    // positive commit: valid pulsed at cycle 5, commit on the cycle-23 edge
    idle(5);
    drive_cycle(1'b1, 1'b1, 7'd45, 1'b0);
    check("pos_ready_low", u_if.result_ready, 0);
    idle(17);
    check("pos_not_yet", display_value, 0);
    idle(1);
    check("pos_value", display_value, 45);
    check("pos_neg", is_negative, 0);
    check("pos_ready_back", u_if.result_ready, 1);

    // free-run scan with blank_en asserted mid-slot
    idle(3);
    for (int i = 0; i < 30; i++) drive_cycle(1'b1, 1'b0, 7'd0, (i >= 4 && i < 14));

    // negative and saturate
    send_until_accepted(7'b1111011);
    idle(30);
    check("neg_value", display_value, 5);
    check("neg_sign", is_negative, 1);
    check("neg_ovf", overflow, 0);
    send_until_accepted(7'b1000000);
    idle(30);
    check("sat_value", display_value, 63);
    check("sat_sign", is_negative, 1);
    check("sat_ovf", overflow, 1);

    // backpressure: 10 then 20 offered back to back
    send_until_accepted(7'd10);
    send_until_accepted(7'd20);
    check("bp_after20_value", display_value, 10);
    idle(30);
    check("bp_final_value", display_value, 20);

    // reset mid-operation with an entry pending at digit 1
    do_reset();
    idle(2);
    send_until_accepted(7'd33);
    for (int i = 0; i < 40 && m_digit() != 1; i++) idle(1);
    check("mid_pending", u_if.result_ready, 0);
    check("mid_digit1", digit, 1);
    drive_cycle(1'b0, 1'b0, 7'd0, 1'b0);
    check("mid_rst_value", display_value, 0);
    check("mid_rst_digit", digit, 0);
    check("mid_rst_anodes", anodes, 4'b1111);
    check("mid_rst_ready", u_if.result_ready, 1);
    idle(40);
    check("mid_lost", display_value, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      drive_cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) == 0),
                  7'($urandom_range(0, 127)), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, giving the clock cycles per digit slot; legal values are CLK_DIV >= 2.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 2, giving the anode-off cycles at the start of each slot; legal values are 1 <= BLANK_CYCLES < CLK_DIV.
REQ-003 clk  input  1  -- the single system clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  -- reset, synchronous and active-low.
REQ-005 result  input  7  -- calculator result, two's-complement signed, range -64..63.
REQ-006 result_valid  input  1  -- result is offered this cycle.
REQ-007 result_ready  output  1  -- the block can accept a result this cycle.
REQ-008 blank_en  input  1  -- when high, forces all anodes off.
REQ-009 digit  output  2  -- active digit index (0 = low hex, 1 = high hex, 2 = sign), fed to the segment decoder.
REQ-010 display_value  output  6  -- committed magnitude.
REQ-011 is_negative  output  1  -- committed sign.
REQ-012 overflow  output  1  -- committed magnitude was saturated.
REQ-013 anodes  output  4  -- active-low digit enables; anodes[3] SHALL be constant 1.

Function
REQ-014 A transfer SHALL occur on a rising edge where result_valid && result_ready.
REQ-015 result_ready SHALL equal !pending_valid, where pending_valid is the state of a one-entry pending buffer.
REQ-016 On a transfer, the block SHALL set pending_neg = result[6].
REQ-017 On a transfer, pending_mag SHALL be |result| truncated to 6 bits, except that result == -64 SHALL store pending_mag = 63 with pending_ovf = 1.
REQ-018 For every other transfer, pending_ovf SHALL be 0.
REQ-019 On a transfer, pending_valid SHALL be set to 1.
REQ-020 Slot counter div_cnt SHALL count 0..CLK_DIV-1, incrementing every cycle and wrapping to 0.
REQ-021 When div_cnt wraps, digit SHALL advance 0 -> 1 -> 2 -> 0; digit SHALL never take the value 3.
REQ-022 The per-slot state SHALL be BLANK while div_cnt < BLANK_CYCLES and DRIVE otherwise.
REQ-023 In BLANK, or whenever blank_en = 1, anodes SHALL be 4'b1111.
REQ-024 In DRIVE with blank_en = 0, anodes[digit] SHALL be 0 and all other anode bits SHALL be 1.
REQ-025 blank_en SHALL NOT stop or alter the counters.
REQ-026 A frame boundary SHALL be the cycle with digit == 2 and div_cnt == CLK_DIV-1.
REQ-027 On the frame-boundary edge with pending_valid = 1, display_value, is_negative and overflow SHALL load pending_mag, pending_neg and pending_ovf, and pending_valid SHALL clear.
REQ-028 Committed outputs SHALL change only at frame boundaries, so that no frame mixes two results.
REQ-029 Because ready = 0 whenever a commit is possible, an accept and a commit SHALL never coincide.
REQ-030 A result accepted in any cycle SHALL commit at the next frame boundary that follows its acceptance edge.
REQ-031 While result_ready = 0, result_valid SHALL be ignored; the block SHALL NOT drop or overwrite the pending entry.
REQ-032 digit, display_value, is_negative, overflow and all counters SHALL be registered.
REQ-033 anodes and result_ready SHALL be combinational from registered state and blank_en only.

Reset
REQ-034 On a rising edge with reset_n = 0, div_cnt SHALL clear to 0 and digit to 0.
REQ-035 On the same edge, display_value, is_negative and overflow SHALL clear to 0.
REQ-036 On the same edge, pending_valid SHALL clear to 0, so result_ready = 1 after reset.
REQ-037 After reset, anodes SHALL be 4'b1111 (BLANK, div_cnt = 0).
REQ-038 Reset applied mid-frame or with an entry pending SHALL discard the pending entry and restart scanning at digit 0, BLANK.
REQ-039 During reset, result_valid SHALL be ignored.

Verification (CLK_DIV = 8, BLANK_CYCLES = 2)
REQ-040 Reset: hold reset_n low 3 cycles, then release -> anodes = 1111, digit = 0, display_value = 0, is_negative = 0, overflow = 0, result_ready = 1.
REQ-041 Scan pattern: free run after reset -> each 8-cycle slot shows 2 cycles of 1111, then 6 cycles of the digit's anode pattern, in the repeating sequence 1110 / 1101 / 1011 with a 24-cycle frame; asserting blank_en mid-slot forces 1111 while digit keeps advancing on schedule.
REQ-042 Positive commit: result = 45 with result_valid pulsed at cycle 5 -> result_ready = 0 from cycle 6; display_value = 45, is_negative = 0 after the cycle-23 edge; result_ready = 1 again.
REQ-043 Negative and saturate: result = -5 (1111011) -> display_value = 5, is_negative = 1, overflow = 0; then result = -64 -> display_value = 63, is_negative = 1, overflow = 1.
REQ-044 Backpressure: results 10 and then 20 held valid on consecutive cycles -> 10 accepted and 20 stalled while result_ready = 0; 10 commits at the boundary, 20 is accepted the next cycle and commits one frame later.
REQ-045 Reset mid-operation: assert reset_n = 0 with an entry pending at digit 1 -> the pending entry is lost, display_value = 0, and scanning restarts at digit 0 BLANK.
